// File: rtl/lc3_pkg.sv
// Shared LC3 encodings: opcodes, decode-field encodings and E_Control bit layout.
package lc3_pkg;

  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpLd  = 4'b0010;
  localparam logic [3:0] OpSt  = 4'b0011;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpStr = 4'b0111;
  localparam logic [3:0] OpNot = 4'b1001;
  localparam logic [3:0] OpLdi = 4'b1010;
  localparam logic [3:0] OpSti = 4'b1011;
  localparam logic [3:0] OpJmp = 4'b1100;
  localparam logic [3:0] OpLea = 4'b1110;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluAnd = 2'b01;
  localparam logic [1:0] AluNot = 2'b10;

  localparam logic [1:0] PcSelNone  = 2'b00;
  localparam logic [1:0] PcSelOff9  = 2'b01;
  localparam logic [1:0] PcSelOff6  = 2'b10;
  localparam logic [1:0] PcSelZero  = 2'b11;

  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbMem = 2'b01;
  localparam logic [1:0] WbPc  = 2'b10;

  // E_Control = {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
  localparam int unsigned EAluLsb   = 4;
  localparam int unsigned EPcSel1Lsb = 2;
  localparam int unsigned EPcSel2   = 1;
  localparam int unsigned EOp2Sel   = 0;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode decoder: maps opcode and imm flag to execute/writeback/memory controls.
module decode_ctrl
  import lc3_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       imm_flag,
  output logic [5:0] e_control,
  output logic [1:0] w_control,
  output logic       mem_control,
  output logic       illegal
);

  always_comb begin
    e_control   = '0;
    w_control   = WbAlu;
    mem_control = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OpAdd: begin
        e_control[EAluLsb +: 2] = AluAdd;
        e_control[EOp2Sel]      = ~imm_flag;
      end
      OpAnd: begin
        e_control[EAluLsb +: 2] = AluAnd;
        e_control[EOp2Sel]      = ~imm_flag;
      end
      OpNot: begin
        e_control[EAluLsb +: 2] = AluNot;
        e_control[EOp2Sel]      = 1'b1;
      end
      OpBr, OpSt: begin
        e_control[EPcSel1Lsb +: 2] = PcSelOff9;
        e_control[EPcSel2]         = 1'b1;
      end
      OpLd: begin
        e_control[EPcSel1Lsb +: 2] = PcSelOff9;
        e_control[EPcSel2]         = 1'b1;
        w_control                  = WbMem;
      end
      OpLdi: begin
        e_control[EPcSel1Lsb +: 2] = PcSelOff9;
        e_control[EPcSel2]         = 1'b1;
        w_control                  = WbMem;
        mem_control                = 1'b1;
      end
      OpSti: begin
        e_control[EPcSel1Lsb +: 2] = PcSelOff9;
        e_control[EPcSel2]         = 1'b1;
        mem_control                = 1'b1;
      end
      OpLea: begin
        e_control[EPcSel1Lsb +: 2] = PcSelOff9;
        e_control[EPcSel2]         = 1'b1;
        w_control                  = WbPc;
      end
      OpLdr: begin
        e_control[EPcSel1Lsb +: 2] = PcSelOff6;
        w_control                  = WbMem;
      end
      OpStr: e_control[EPcSel1Lsb +: 2] = PcSelOff6;
      OpJmp: e_control[EPcSel1Lsb +: 2] = PcSelZero;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode.sv
// LC3 decode stage: registers the fetched instruction, next-PC and decoded control bundles.
module decode
  import lc3_pkg::*;
#(
  parameter logic [15:0] RESET_IR = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_Control,
  output logic [1:0]  W_Control,
  output logic        Mem_Control,
  output logic        illegal_op,
  output logic        decode_valid
);

  logic [5:0] e_d;
  logic [1:0] w_d;
  logic       mem_d;
  logic       illegal_d;

  decode_ctrl u_ctrl (
    .opcode      (dout[15:12]),
    .imm_flag    (dout[5]),
    .e_control   (e_d),
    .w_control   (w_d),
    .mem_control (mem_d),
    .illegal     (illegal_d)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      IR           <= RESET_IR;
      npc_out      <= '0;
      E_Control    <= '0;
      W_Control    <= '0;
      Mem_Control  <= 1'b0;
      illegal_op   <= 1'b0;
      decode_valid <= 1'b0;
    end else if (enable_decode) begin
      IR           <= dout;
      npc_out      <= npc_in;
      E_Control    <= e_d;
      W_Control    <= w_d;
      Mem_Control  <= mem_d;
      illegal_op   <= illegal_d;
      decode_valid <= 1'b1;
    end
  end

endmodule

// File: doc/decode.md
# decode

Instruction decode stage of the LC3 microcontroller pipeline, directly downstream of the fetch stage. It captures the 16-bit instruction word returned by instruction memory (`dout`) and the fetch stage's next-PC, then produces registered control bundles for execute, writeback and memory. Capture happens only on cycles enabled by the controller, so the block stalls in step with fetch.

## Interface
Parameters:
- `RESET_IR`, 16'h0000: IR value after reset.

Ports:
- `clock`, in, 1: single clock; every flop is clocked on the rising edge.
- `reset`, in, 1: asynchronous, active-low; clears all state immediately.
- `enable_decode`, in, 1: capture strobe from the controller.
- `dout`, in, 16: instruction word from instruction memory.
- `npc_in`, in, 16: next PC from fetch (PC+1).
- `IR`, out, 16: latched instruction.
- `npc_out`, out, 16: latched `npc_in`.
- `E_Control`, out, 6: {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- `W_Control`, out, 2: writeback mux select.
- `Mem_Control`, out, 1: indirect-access flag.
- `illegal_op`, out, 1: the latched opcode is unsupported.
- `decode_valid`, out, 1: at least one instruction has been decoded since reset.

## Operation
- Opcode is `dout[15:12]`. Supported opcodes: ADD 0001, AND 0101, NOT 1001, BR 0000, JMP 1100, LD 0010, LDR 0110, LDI 1010, LEA 1110, ST 0011, STR 0111, STI 1011.
- `alu_control`:
  - ADD = 00, AND = 01, NOT = 10.
  - All other opcodes = 00.
- `pcselect1`:
  - BR/LD/LDI/LEA/ST/STI = 01 (offset9).
  - LDR/STR = 10 (offset6).
  - JMP = 11 (zero offset).
  - ALU ops = 00.
- `pcselect2`:
  - 1 (base = NPC) for BR/LD/LDI/LEA/ST/STI.
  - 0 (base = VSR1) otherwise.
- `op2select`:
  - ADD/AND: the complement of `dout[5]` (1 = register operand, 0 = imm5).
  - NOT: 1.
  - All other opcodes: 0.
- `W_Control`:
  - ADD/AND/NOT = 00 (ALU).
  - LD/LDR/LDI = 01 (memory).
  - LEA = 10 (PC-relative).
  - All other opcodes = 00.
- `Mem_Control` = 1 only for LDI and STI.
- Unsupported opcodes (0100, 1000, 1101, 1111):
  - `illegal_op` = 1.
  - `E_Control`, `W_Control` and `Mem_Control` are forced to zero.
  - `IR` and `npc_out` still latch normally.
- `decode_valid` sets on the first enabled capture and stays set until the next reset.

## Timing
- Reset values while `reset` is low:
  - `IR` = `RESET_IR`.
  - `npc_out`, `E_Control`, `W_Control`, `Mem_Control`, `illegal_op` and `decode_valid` = 0.
- Latency: `dout` and `npc_in` are sampled at the rising edge where `enable_decode` = 1. Every output reflects them from that edge onward (1 cycle).
- `enable_decode` = 0: all outputs hold their values, whatever `dout` and `npc_in` do.
- Every output is registered; there is no combinational path from inputs to outputs.
- Asserting `reset` mid-operation clears outputs at once, with no clock needed. The first edge after deassertion with `enable_decode` = 1 captures normally.
- Back-to-back enables: each edge captures a new instruction; no bubble is inserted.

## Structure
- Shared package `lc3_pkg` holds:
  - opcode localparams;
  - `alu_control`, `pcselect1` and `W_Control` encodings;
  - E_Control field offsets.
- Optional combinational sub-module `decode_ctrl`: maps the instruction to {E, W, Mem, illegal}. The `decode` top registers its outputs together with `IR` and `npc_out`.

## Test plan
- Reset then idle: hold `reset` low, toggle `dout` → all outputs stay 0 and `IR` = 16'h0000. Release reset with `enable_decode` = 0 → outputs hold.
- Register-form ALU ops: `dout` = 16'h1283, `npc_in` = 16'h3001, enable for 1 cycle → next edge `IR` = 16'h1283, `npc_out` = 16'h3001, `E_Control` = 6'h01, `W_Control` = 0, `decode_valid` = 1. Then 16'h5283 → `E_Control` = 6'h11.
- Immediate-form and NOT: 16'h12A5 → `E_Control` = 6'h00. 16'h923F → `E_Control` = 6'h21, `W_Control` = 00.
- Memory and PC ops:
  - 16'h6701 (LDR) → `E_Control` = 6'h08, `W_Control` = 01, `Mem_Control` = 0.
  - 16'hA002 (LDI) → `E_Control` = 6'h06, `W_Control` = 01, `Mem_Control` = 1.
  - 16'hE005 (LEA) → `E_Control` = 6'h06, `W_Control` = 10.
  - 16'hC1C0 (JMP) → `E_Control` = 6'h0C.
- Stall: capture 16'h1283, then drop `enable_decode` for 3 cycles while `dout` = 16'hB002 → outputs remain those of 16'h1283. Re-enable → STI decode with `Mem_Control` = 1 and `E_Control` = 6'h06.
- Illegal and async reset: 16'hF025 → `illegal_op` = 1, all control outputs 0, `IR` = 16'hF025. Pulse `reset` low between clock edges → everything clears immediately, including `decode_valid`.
